// File: rtl/uart_rx_axis_framer.sv
// UART receive framer: holds each byte until its last-flag is known, then queues
// it in a first-word-fall-through FIFO and presents it as an AXI-Stream master.
module uart_rx_axis_framer #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int IDLE_TIMEOUT = 8680,
    parameter int MAX_PKT      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_valid,
    output logic [WIDTH-1:0]           m_axis_data,
    output logic                       m_axis_valid,
    output logic                       m_axis_last,
    input  logic                       m_axis_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(IDLE_TIMEOUT);
    localparam int LW = $clog2(MAX_PKT + 1);

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_PKT);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_e;

    hold_state_e      state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [LW-1:0]    pkt_len_q, pkt_len_d;
    logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   head;

    logic             push, push_last, push_ok, pop, full;

    // Hold stage: decides when the held byte is pushed and with which last-flag
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pkt_len_d  = pkt_len_q;
        idle_cnt_d = idle_cnt_q;
        push       = 1'b0;
        push_last  = 1'b0;
        unique case (state_q)
            HOLD_EMPTY: begin
                if (rx_valid) begin
                    pend_d     = rx_data;
                    pkt_len_d  = LW'(1);
                    idle_cnt_d = '0;
                    state_d    = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (rx_valid) begin
                    push       = 1'b1;
                    push_last  = (pkt_len_q == LEN_MAX);
                    pend_d     = rx_data;
                    pkt_len_d  = push_last ? LW'(1) : pkt_len_q + LW'(1);
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    push       = 1'b1;
                    push_last  = 1'b1;
                    pkt_len_d  = '0;
                    idle_cnt_d = '0;
                    state_d    = HOLD_EMPTY;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            default: state_d = HOLD_EMPTY;
        endcase
    end

    assign full    = (count_q == CNT_FULL);
    assign pop     = m_axis_valid && m_axis_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD_EMPTY;
            pend_q     <= '0;
            pkt_len_q  <= '0;
            idle_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pkt_len_q  <= pkt_len_d;
            idle_cnt_q <= idle_cnt_d;
            count_q    <= count_d;
            overflow_q <= push && !push_ok;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {push_last, pend_q};
    end

    assign head         = mem_q[rd_ptr_q];
    assign m_axis_valid = (count_q != '0);
    // Outputs are masked while empty so stale storage never shows on the bus
    assign m_axis_data  = m_axis_valid ? head[WIDTH-1:0] : '0;
    assign m_axis_last  = m_axis_valid & head[WIDTH];
    assign overflow     = overflow_q;
    assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_rx_axis_framer.sv
// Scoreboard bench for uart_rx_axis_framer: a transaction-level framing model
// queues expected beats as bytes are driven; a negedge monitor checks them.
module tb_uart_rx_axis_framer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int T     = 10;
    localparam int MAXP  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] m_axis_data;
    logic             m_axis_valid;
    logic             m_axis_last;
    logic             m_axis_ready;
    logic             overflow;
    logic [2:0]       fifo_count;

    uart_rx_axis_framer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .IDLE_TIMEOUT(T),
        .MAX_PKT(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .m_axis_data(m_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_last(m_axis_last),
        .m_axis_ready(m_axis_ready),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned ovf_seen = 0;
    int unsigned ovf_exp = 0;

    logic [WIDTH:0] exp_q [$];
    logic [WIDTH:0] mon_e;

    logic [WIDTH-1:0] m_pend;
    logic             m_pend_valid = 1'b0;
    int unsigned      m_len = 0;
    int unsigned      m_since = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic last);
        if (exp_q.size() >= DEPTH && !m_axis_ready) ovf_exp++;
        else exp_q.push_back({last, m_pend});
    endtask

    task automatic send(input logic [WIDTH-1:0] b);
        logic l;
        rx_data  = b;
        rx_valid = 1'b1;
        if (m_pend_valid) begin
            l = (m_len == MAXP);
            model_push(l);
            m_len = l ? 1 : m_len + 1;
        end else begin
            m_len = 1;
        end
        m_pend       = b;
        m_pend_valid = 1'b1;
        m_since      = 0;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            if (m_pend_valid) begin
                m_since++;
                if (m_since == T) begin
                    model_push(1'b1);
                    m_pend_valid = 1'b0;
                    m_len        = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_seen++;
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_unexpected", 32'(m_axis_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("beat_data", 32'(m_axis_data), 32'(mon_e[WIDTH-1:0]));
                    check_eq("beat_last", 32'(m_axis_last), 32'(mon_e[WIDTH]));
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(m_axis_valid), 32'd0);
        check_eq({tag, "_last"},  32'(m_axis_last),  32'd0);
        check_eq({tag, "_data"},  32'(m_axis_data),  32'd0);
        check_eq({tag, "_ovf"},   32'(overflow),     32'd0);
        check_eq({tag, "_count"}, 32'(fifo_count),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        rx_valid     = 1'b0;
        rx_data      = '0;
        m_axis_ready = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Idle close with exact latency
        send(8'h11);
        idle(4);
        send(8'h22);
        check_eq("idle_first_valid", 32'(m_axis_valid), 32'd1);
        check_eq("idle_first_data",  32'(m_axis_data),  32'h11);
        check_eq("idle_first_last",  32'(m_axis_last),  32'd0);
        idle(9);
        check_eq("idle_before_flush_valid", 32'(m_axis_valid), 32'd0);
        idle(1);
        check_eq("idle_flush_valid", 32'(m_axis_valid), 32'd1);
        check_eq("idle_flush_data",  32'(m_axis_data),  32'h22);
        check_eq("idle_flush_last",  32'(m_axis_last),  32'd1);
        idle(3);
        check_eq("drain_idle", exp_q.size(), 32'd0);

        // Max length framing
        for (int unsigned i = 0; i < 7; i++) begin
            send(8'hA0 + 8'(i));
            idle(1);
        end
        idle(T + 3);
        check_eq("drain_maxlen", exp_q.size(), 32'd0);

        // Backpressure and overflow
        m_axis_ready = 1'b0;
        for (int unsigned i = 1; i <= 5; i++) begin
            send(8'(i));
            idle(1);
        end
        send(8'h06);
        check_eq("bp_count_full", 32'(fifo_count), 32'd4);
        check_eq("bp_ovf_pulse",  32'(overflow),   32'd1);
        idle(1);
        check_eq("bp_ovf_clear",  32'(overflow),   32'd0);
        m_axis_ready = 1'b1;
        idle(T + 4);
        check_eq("drain_bp", exp_q.size(), 32'd0);

        // Full FIFO with a simultaneous pop
        m_axis_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            send(8'hB0 + 8'(i));
            idle(1);
        end
        check_eq("fp_count_before", 32'(fifo_count), 32'd4);
        m_axis_ready = 1'b1;
        send(8'hB5);
        check_eq("fp_count_after", 32'(fifo_count), 32'd4);
        check_eq("fp_no_ovf",      32'(overflow),   32'd0);
        idle(T + 6);
        check_eq("drain_fp", exp_q.size(), 32'd0);

        // Collision of rx_valid with the expiry cycle
        send(8'hC0);
        idle(T - 1);
        send(8'hC1);
        idle(T + 3);
        check_eq("drain_collision", exp_q.size(), 32'd0);

        // Reset mid-packet
        m_axis_ready = 1'b0;
        send(8'hD0);
        idle(1);
        send(8'hD1);
        idle(1);
        check_eq("rst_pre_count", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        m_pend_valid = 1'b0;
        m_len        = 0;
        m_since      = 0;
        tick();
        rst = 1'b0;
        check_outputs_zero("rst_mid");
        m_axis_ready = 1'b1;
        idle(T + 2);
        check_eq("rst_no_flush_valid", 32'(m_axis_valid), 32'd0);
        for (int unsigned i = 0; i < 4; i++) begin
            send(8'hE0 + 8'(i));
            idle(1);
        end
        idle(T + 3);
        check_eq("drain_rst", exp_q.size(), 32'd0);

        check_eq("ovf_total", ovf_seen, ovf_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
